// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: turns raw PS/2 scan bytes into key press/release events.
// Tracks the make / F0 break / E0 extended prefix protocol, holds the pressed
// key for the segment display and counts distinct presses (typematic repeats
// are ignored). Optional build macro PS2_KC_BCD_EN selects a two-digit packed
// BCD press counter instead of an 8-bit binary one.
module ps2_key_ctrl #(
    parameter int TIMEOUT = 1_000_000,
    parameter int TO_W    = 20
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       code_valid,
    input  logic [7:0] code,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       disp_en,
    output logic [7:0] press_cnt,
    output logic       press_pulse,
    output logic       rel_pulse,
    output logic       err_pulse
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HELD    = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT     = 3'd3;
    localparam logic [2:0] S_EXT_BRK = 3'd4;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [7:0]      kc_q, kc_d;
    logic            kx_q, kx_d;
    logic            de_q, de_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            pp_q, pp_d;
    logic            rp_q, rp_d;
    logic            ep_q, ep_d;

    logic            press_req;
    logic            press_ext;
    logic            in_prefix;
    logic [7:0]      cnt_inc;

    // Press counter increment, binary or packed BCD depending on the build
`ifdef PS2_KC_BCD_EN
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q[3:0] == 4'd9) begin
            cnt_inc[3:0] = 4'd0;
            cnt_inc[7:4] = (cnt_q[7:4] == 4'd9) ? 4'd0 : cnt_q[7:4] + 4'd1;
        end else begin
            cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
        end
    end
`else
    assign cnt_inc = cnt_q + 8'd1;
`endif

    assign in_prefix = (state_q == S_BRK) || (state_q == S_EXT) || (state_q == S_EXT_BRK);

    // Protocol FSM, timeout counter and output next-state
    always_comb begin
        state_d   = state_q;
        to_d      = to_q;
        kc_d      = kc_q;
        kx_d      = kx_q;
        de_d      = de_q;
        cnt_d     = cnt_q;
        pp_d      = 1'b0;
        rp_d      = 1'b0;
        ep_d      = 1'b0;
        press_req = 1'b0;
        press_ext = 1'b0;
        if (code_valid) begin
            // A byte always beats a same-cycle expiry
            to_d = '0;
            case (state_q)
                S_IDLE, S_HELD: begin
                    if (code == B_EXT)      state_d = S_EXT;
                    else if (code == B_BRK) state_d = S_BRK;
                    else                    press_req = 1'b1;
                end
                S_EXT: begin
                    if (code == B_BRK)      state_d = S_EXT_BRK;
                    else if (code != B_EXT) begin
                        press_req = 1'b1;
                        press_ext = 1'b1;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    if (code == B_EXT || code == B_BRK) begin
                        ep_d    = 1'b1;
                        de_d    = 1'b0;
                        state_d = S_IDLE;
                    end else if (de_q && code == kc_q && kx_q == (state_q == S_EXT_BRK)) begin
                        de_d    = 1'b0;
                        rp_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Break for a key that is not held: swallow it
                        state_d = de_q ? S_HELD : S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            if (press_req) begin
                state_d = S_HELD;
                // Same key still held means typematic repeat: no count, no pulse
                if (!(de_q && code == kc_q && press_ext == kx_q)) begin
                    kc_d  = code;
                    kx_d  = press_ext;
                    de_d  = 1'b1;
                    cnt_d = cnt_inc;
                    pp_d  = 1'b1;
                end
            end
        end else if (in_prefix) begin
            if (to_q == TO_LAST) begin
                ep_d    = 1'b1;
                to_d    = '0;
                state_d = de_q ? S_HELD : S_IDLE;
            end else begin
                to_d = to_q + 1'b1;
            end
        end else begin
            to_d = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            to_q    <= '0;
            kc_q    <= 8'h00;
            kx_q    <= 1'b0;
            de_q    <= 1'b0;
            cnt_q   <= 8'h00;
            pp_q    <= 1'b0;
            rp_q    <= 1'b0;
            ep_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            kc_q    <= kc_d;
            kx_q    <= kx_d;
            de_q    <= de_d;
            cnt_q   <= cnt_d;
            pp_q    <= pp_d;
            rp_q    <= rp_d;
            ep_q    <= ep_d;
        end
    end

    assign key_code    = kc_q;
    assign key_ext     = kx_q;
    assign disp_en     = de_q;
    assign press_cnt   = cnt_q;
    assign press_pulse = pp_q;
    assign rel_pulse   = rp_q;
    assign err_pulse   = ep_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: scoreboard bench for ps2_key_ctrl (TIMEOUT shortened to 16).
module tb_ps2_key_ctrl;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] key_code;
    logic       key_ext;
    logic       disp_en;
    logic [7:0] press_cnt;
    logic       press_pulse;
    logic       rel_pulse;
    logic       err_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] kc;
        logic       kx;
        logic       de;
        logic [7:0] pc;
        logic       pp;
        logic       rp;
        logic       ep;
    } exp_t;

    exp_t exp_q[$];

    ps2_key_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
        .clk(clk), .resetn(resetn), .code_valid(code_valid), .code(code),
        .key_code(key_code), .key_ext(key_ext), .disp_en(disp_en),
        .press_cnt(press_cnt), .press_pulse(press_pulse),
        .rel_pulse(rel_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [7:0] kc, input logic kx, input logic de,
                                input logic [7:0] pc, input logic pp, input logic rp,
                                input logic ep);
        exp_t e;
        e.kc = kc; e.kx = kx; e.de = de; e.pc = pc; e.pp = pp; e.rp = rp; e.ep = ep;
        return e;
    endfunction

    // Scoreboard: every consumed byte has one queued expectation
    always @(posedge clk) begin
        if (code_valid && resetn) begin
            exp_t e, a;
            #1;
            a = {key_code, key_ext, disp_en, press_cnt, press_pulse, rel_pulse, err_pulse};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: output %h with no expectation queued", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL sb_byte: got kc=%h kx=%b de=%b cnt=%h pp=%b rp=%b ep=%b, want kc=%h kx=%b de=%b cnt=%h pp=%b rp=%b ep=%b",
                             a.kc, a.kx, a.de, a.pc, a.pp, a.rp, a.ep,
                             e.kc, e.kx, e.de, e.pc, e.pp, e.rp, e.ep);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input exp_t e);
        @(negedge clk);
        code_valid = 1'b1;
        code = b;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({key_code, key_ext, disp_en, press_cnt, press_pulse, rel_pulse, err_pulse} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got kc=%h de=%b cnt=%h, want all zero", key_code, disp_en, press_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_make_break();
        do_reset();
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'd1, 1, 0, 0));
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'h1C, mk(8'h1C, 0, 0, 8'd1, 0, 1, 0));
    endtask

    task automatic test_typematic();
        do_reset();
        send_byte(8'h16, mk(8'h16, 0, 1, 8'd1, 1, 0, 0));
        send_byte(8'h16, mk(8'h16, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'h16, mk(8'h16, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'hF0, mk(8'h16, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'h16, mk(8'h16, 0, 0, 8'd1, 0, 1, 0));
    endtask

    task automatic test_ext();
        do_reset();
        send_byte(8'hE0, mk(8'h00, 0, 0, 8'd0, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 1, 8'd1, 1, 0, 0));
        // Plain break of an extended key must not release it
        send_byte(8'hF0, mk(8'h75, 1, 1, 8'd1, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 1, 8'd1, 0, 0, 0));
        checks++;
        if (disp_en !== 1'b1) begin
            errors++;
            $display("FAIL ext_plain_break: disp_en=%b, want 1", disp_en);
        end
        send_byte(8'hE0, mk(8'h75, 1, 1, 8'd1, 0, 0, 0));
        send_byte(8'hF0, mk(8'h75, 1, 1, 8'd1, 0, 0, 0));
        send_byte(8'h75, mk(8'h75, 1, 0, 8'd1, 0, 1, 0));
    endtask

    task automatic test_timeout();
        int bad;
        // Held key, dangling F0: error at cycle 16, key stays displayed
        do_reset();
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'd1, 1, 0, 0));
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        bad = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (err_pulse !== (k == TIMEOUT)) bad = k;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_held: err_pulse wrong at idle cycle %0d, want pulse only at %0d", bad, TIMEOUT);
        end
        checks++;
        if (disp_en !== 1'b1 || key_code !== 8'h1C) begin
            errors++;
            $display("FAIL timeout_keep: de=%b kc=%h, want de=1 kc=1c", disp_en, key_code);
        end
        // Back in S_HELD: same key is a repeat, not a release
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));

        // Byte arriving on the expiry cycle wins
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        bad = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            @(posedge clk);
            #1;
            if (err_pulse !== 1'b0) bad = k;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early: err_pulse=1 at idle cycle %0d, want 0", bad);
        end
        send_byte(8'h1C, mk(8'h1C, 0, 0, 8'd1, 0, 1, 0));

        // No key held: timeout returns to S_IDLE
        do_reset();
        send_byte(8'hF0, mk(8'h00, 0, 0, 8'd0, 0, 0, 0));
        bad = 0;
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk);
            #1;
            if (err_pulse !== (k == TIMEOUT)) bad = k;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_idle: err_pulse wrong at idle cycle %0d, want pulse only at %0d", bad, TIMEOUT);
        end
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'd1, 1, 0, 0));
        // F0 followed by a prefix byte is a protocol error
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'hE0, mk(8'h1C, 0, 0, 8'd1, 0, 0, 1));
    endtask

    task automatic test_count();
        logic [7:0] c;
        logic [7:0] want;
        int n;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            n = i + 1;
            c = (i % 2 == 1) ? 8'h22 : 8'h21;
`ifdef PS2_KC_BCD_EN
            want = {4'((n % 100) / 10), 4'(n % 10)};
`else
            want = 8'(n % 256);
`endif
            send_byte(c, mk(c, 0, 1, want, 1, 0, 0));
            if (n == 10 || n == 100 || n == 256) begin
                checks++;
                if (press_cnt !== want) begin
                    errors++;
                    $display("FAIL count_%0d: press_cnt=%h, want %h", n, press_cnt, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_seq();
        do_reset();
        send_byte(8'h1C, mk(8'h1C, 0, 1, 8'd1, 1, 0, 0));
        send_byte(8'hE0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'hF0, mk(8'h1C, 0, 1, 8'd1, 0, 0, 0));
        #1;
        resetn = 1'b0;
        #1;
        checks++;
        if ({key_code, key_ext, disp_en, press_cnt, press_pulse, rel_pulse, err_pulse} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got kc=%h de=%b cnt=%h, want all zero", key_code, disp_en, press_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        send_byte(8'h75, mk(8'h75, 0, 1, 8'd1, 1, 0, 0));
        // Orphan break afterwards: F0 then an unheld key changes nothing
        send_byte(8'hF0, mk(8'h75, 0, 1, 8'd1, 0, 0, 0));
        send_byte(8'h33, mk(8'h75, 0, 1, 8'd1, 0, 0, 0));
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_ext();
        test_timeout();
        test_count();
        test_reset_mid_seq();
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expectations unconsumed, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
